// File: rtl/mac_int_fsm.sv
// Signed 16x16 multiply-accumulate sequenced by a four-state FSM.
// One operation takes IDLE->MULT->ACCUM->DONE; the accumulator persists until reset.
module mac_int_fsm (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic signed [15:0] A,
    input  logic signed [15:0] B,
    output logic signed [31:0] y,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, MULT, ACCUM, DONE} state_t;

    state_t             state, nxt;
    logic signed [15:0] a_r, b_r;
    logic signed [31:0] prod;
    logic signed [31:0] acc;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (valid) nxt = MULT;
            MULT:    nxt = ACCUM;
            ACCUM:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // done is a pure state decode, so valid never reaches it combinationally
    always_comb begin
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r  <= '0;
            b_r  <= '0;
            prod <= '0;
            acc  <= '0;
        end else begin
            case (state)
                IDLE:  if (valid) begin
                    a_r <= A;
                    b_r <= B;
                end
                MULT:  prod <= a_r * b_r;
                ACCUM: acc  <= acc + prod;
                default: ;
            endcase
        end
    end

    assign y = acc;

endmodule

// File: tb/tb_mac_int_fsm.sv
// Self-checking bench for mac_int_fsm: directed literal checks plus randomized
// traffic compared every cycle against an operation-level reference model.
module tb_mac_int_fsm;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               valid = 1'b0;
    logic signed [15:0] A = '0;
    logic signed [15:0] B = '0;
    logic signed [31:0] y;
    logic               done;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    mac_int_fsm dut (
        .clk  (clk),
        .reset(reset),
        .valid(valid),
        .A    (A),
        .B    (B),
        .y    (y),
        .done (done)
    );

    always #5 clk = ~clk;

    // Reference: an operation accepted when idle finishes three edges later;
    // the sum lands on the third edge and done shows for the cycle after it.
    int                 m_age  = 0;   // 0 = idle, else edges since acceptance
    longint             m_prod = 0;
    logic signed [31:0] m_acc  = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_age  = 0;
            m_prod = 0;
            m_acc  = '0;
        end else if (m_age == 0) begin
            if (valid) begin
                m_prod = longint'(A) * longint'(B);
                m_age  = 1;
            end
        end else begin
            if (m_age == 2) m_acc = m_acc + 32'(m_prod);
            m_age = (m_age == 3) ? 0 : m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            total++;
            if (y !== m_acc) begin
                bad++;
                $display("FAIL cycle_y: got %0d expected %0d at %0t", y, m_acc, $time);
            end
            total++;
            if (done !== (m_age == 3)) begin
                bad++;
                $display("FAIL cycle_done: got %0b expected %0b at %0t", done, (m_age == 3), $time);
            end
        end
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic signed [15:0] a, input logic signed [15:0] b);
        valid = v;
        A     = a;
        B     = b;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 16'sd0, 16'sd0);
        reset = 1'b0;
    endtask

    // One accepted op; junk=1 pulses valid with other operands while busy.
    task automatic op(input string name, input logic signed [15:0] a, input logic signed [15:0] b,
                      input bit junk, input logic signed [31:0] exp_y);
        step(1'b1, a, b);
        step(junk, 16'sd111, -16'sd77);
        step(junk, -16'sd9, 16'sd1234);
        chk({name, "_y"}, y, exp_y);
        chk({name, "_done"}, {31'd0, done}, 32'sd1);
        step(junk, 16'sd500, 16'sd500);
        chk({name, "_done_low"}, {31'd0, done}, 32'sd0);
    endtask

    initial begin
        do_reset();
        checking = 1'b1;
        chk("reset_y", y, 32'sd0);
        chk("reset_done", {31'd0, done}, 32'sd0);

        op("op30x40", 16'sd30, 16'sd40, 1'b0, 32'sd1200);
        op("seq1", 16'sd10,  16'sd16, 1'b0, 32'sd1360);
        op("seq2", 16'sd50,  16'sd25, 1'b0, 32'sd2610);
        op("seq3", 16'sd100, 16'sd23, 1'b0, 32'sd4910);
        op("seq4", 16'sd100, 16'sd24, 1'b0, 32'sd7310);

        do_reset();
        chk("rst_after_seq_y", y, 32'sd0);
        chk("rst_after_seq_done", {31'd0, done}, 32'sd0);
        op("op2x3", 16'sd2, 16'sd3, 1'b0, 32'sd6);

        do_reset();
        op("neg3x7", -16'sd3, 16'sd7, 1'b0, -32'sd21);
        op("neg4xneg5", -16'sd4, -16'sd5, 1'b0, -32'sd1);

        do_reset();
        op("ignored_valid", 16'sd5, 16'sd6, 1'b1, 32'sd30);

        // valid held high: back-to-back acceptance every fourth edge
        do_reset();
        op("held1", 16'sd7, 16'sd8, 1'b1, 32'sd56);
        op("held2", 16'sd7, 16'sd8, 1'b1, 32'sd112);

        do_reset();
        op("wrap1", 16'sd32767, 16'sd32767, 1'b0, 32'sd1073676289);
        op("wrap2", 16'sd32767, 16'sd32767, 1'b0, 32'sd2147352578);
        op("wrap3", 16'sd32767, 16'sd32767, 1'b0, -32'sd1073938429);
        op("wrap4", 16'sd32767, 16'sd32767, 1'b0, -32'sd262140);

        // reset landing on the ACCUM edge must leave nothing behind
        step(1'b1, 16'sd1000, 16'sd1000);
        step(1'b0, 16'sd0, 16'sd0);
        do_reset();
        chk("rst_in_accum_y", y, 32'sd0);
        chk("rst_in_accum_done", {31'd0, done}, 32'sd0);
        step(1'b0, 16'sd0, 16'sd0);
        chk("rst_in_accum_no_done", {31'd0, done}, 32'sd0);
        op("after_rst_first", 16'sd4, 16'sd4, 1'b0, 32'sd16);

        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        end
        reset = 1'b0;
        repeat (5) step(1'b0, 16'sd0, 16'sd0);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
